// File: rtl/frame_capture_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_capture_pkg
//  Description : Shared definitions for the frame capture scheduler: FSM
//                state encoding and default sizing constants.
//  Optional    : FRAME_CAPTURE_SCHED_DECIM_EN (not used in this file)
//  Revision    : 1.0  initial release
// ============================================================================
package frame_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam int c_CNT_W_DEF          = 8;
    localparam int c_TIMEOUT_CYCLES_DEF = 65535;
    localparam int c_TO_W_DEF           = 16;

endpackage : frame_capture_pkg
`default_nettype wire

// File: rtl/frame_capture_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_capture_sched_if
//  Description : Host / sensor / writer bundle for frame_capture_sched.
//                master = host-side driver, slave = scheduler.
//  Signals     : ARM, HOST_REQ, SOF, DONE (to scheduler)
//                CAPTURE_EN, STATE, FRAME_CNT, MATCH, ERR_TIMEOUT (from it)
//                DECIM[3:0] (to scheduler, only with the optional macro)
//  Optional    : FRAME_CAPTURE_SCHED_DECIM_EN adds the DECIM signal
//  Revision    : 1.0  initial release
// ============================================================================
interface frame_capture_sched_if
    import frame_capture_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEF
) ();
    logic             ARM;
    logic [CNT_W-1:0] HOST_REQ;
    logic             SOF;
    logic             DONE;
    logic             CAPTURE_EN;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] FRAME_CNT;
    logic             MATCH;
    logic             ERR_TIMEOUT;
`ifdef FRAME_CAPTURE_SCHED_DECIM_EN
    logic [3:0]       DECIM;

    modport master (output ARM, HOST_REQ, SOF, DONE, DECIM,
                    input  CAPTURE_EN, STATE, FRAME_CNT, MATCH, ERR_TIMEOUT);
    modport slave  (input  ARM, HOST_REQ, SOF, DONE, DECIM,
                    output CAPTURE_EN, STATE, FRAME_CNT, MATCH, ERR_TIMEOUT);
`else
    modport master (output ARM, HOST_REQ, SOF, DONE,
                    input  CAPTURE_EN, STATE, FRAME_CNT, MATCH, ERR_TIMEOUT);
    modport slave  (input  ARM, HOST_REQ, SOF, DONE,
                    output CAPTURE_EN, STATE, FRAME_CNT, MATCH, ERR_TIMEOUT);
`endif
endinterface : frame_capture_sched_if
`default_nettype wire

// File: rtl/frame_capture_sched_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : capture_watchdog
//  Description : Per-frame watchdog. Up-counter with synchronous clear and
//                enable; o_tc flags the terminal count TIMEOUT_CYCLES-1 and
//                the counter holds there until cleared.
//  Ports       : clk, rst (async, active-high), i_clr, i_en, o_tc
//  Optional    : FRAME_CAPTURE_SCHED_DECIM_EN (not used in this file)
//  Revision    : 1.0  initial release
// ============================================================================
module capture_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_tc
);
    localparam logic [TO_W-1:0] c_TERMINAL = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == c_TERMINAL);

endmodule : capture_watchdog
`default_nettype wire

// File: rtl/frame_capture_sched.sv
`default_nettype none
// ============================================================================
//  Module      : frame_capture_sched
//  Description : Sequences one sensor-to-file frame capture per host request.
//                A mismatch between HOST_REQ and the completed-frame counter
//                arms the FSM, which waits for SOF, gates the frame writer
//                via CAPTURE_EN until DONE, and aborts to a sticky ERROR state
//                if the writer stalls past the watchdog limit.
//  Ports       : CLOCK, RESET (async, active-high)
//                bus : frame_capture_sched_if.slave
//  Optional    : FRAME_CAPTURE_SCHED_DECIM_EN -- only every (DECIM+1)th SOF
//                seen in WAIT_SOF starts a capture.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_capture_sched
    import frame_capture_pkg::*;
#(
    parameter int CNT_W          = c_CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF,
    parameter int TO_W           = c_TO_W_DEF
) (
    input  wire logic            CLOCK,
    input  wire logic            RESET,
    frame_capture_sched_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_capture_en;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_err;
    logic             w_match;
    logic             w_sof_go;
    logic             w_frame_inc;
    logic             w_to_hit;
    logic             w_wd_tc;
    logic             w_wd_clr;

    assign w_match = (bus.HOST_REQ == r_frame_cnt);

`ifdef FRAME_CAPTURE_SCHED_DECIM_EN
    // Counts SOFs skipped in WAIT_SOF; held at zero in every other state so
    // it is always zero on entry to WAIT_SOF.
    logic [3:0] r_sof_cnt;

    assign w_sof_go = bus.SOF && (r_sof_cnt == bus.DECIM);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_sof_cnt <= '0;
        end else if (r_state != ST_WAIT_SOF) begin
            r_sof_cnt <= '0;
        end else if (bus.SOF && !w_sof_go) begin
            r_sof_cnt <= r_sof_cnt + 1'b1;
        end
    end
`else
    assign w_sof_go = bus.SOF;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_frame_inc = 1'b0;
        w_to_hit    = 1'b0;
        if (!bus.ARM) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_match) w_state_nxt = ST_WAIT_SOF;
                end
                ST_WAIT_SOF: begin
                    // DONE is meaningless here: no frame is open.
                    if (w_sof_go) w_state_nxt = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // DONE beats both a coincident SOF and the terminal count.
                    if (bus.DONE) begin
                        w_state_nxt = ST_IDLE;
                        w_frame_inc = 1'b1;
                    end else if (w_wd_tc) begin
                        w_state_nxt = ST_ERROR;
                        w_to_hit    = 1'b1;
                    end
                end
                ST_ERROR: begin
                    w_state_nxt = ST_ERROR;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_capture_en <= 1'b0;
            r_frame_cnt  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_capture_en <= (w_state_nxt == ST_CAPTURE);
            if (!bus.ARM) begin
                r_frame_cnt <= '0;
                r_err       <= 1'b0;
            end else begin
                if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 1'b1;
                if (w_to_hit)    r_err       <= 1'b1;
            end
        end
    end

    // Watchdog runs only across consecutive CAPTURE cycles: it reads zero on
    // the first CAPTURE cycle and returns to zero whenever CAPTURE is left.
    assign w_wd_clr = (r_state != ST_CAPTURE) || (w_state_nxt != ST_CAPTURE);

    capture_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk   (CLOCK),
        .rst   (RESET),
        .i_clr (w_wd_clr),
        .i_en  (r_state == ST_CAPTURE),
        .o_tc  (w_wd_tc)
    );

    assign bus.CAPTURE_EN  = r_capture_en;
    assign bus.STATE       = r_state;
    assign bus.FRAME_CNT   = r_frame_cnt;
    assign bus.MATCH       = w_match;
    assign bus.ERR_TIMEOUT = r_err;

endmodule : frame_capture_sched
`default_nettype wire
